regfile_bypass_sb: RTL and testbench

Parametrised successor to the single-write general-purpose register file.
- Two write ports, two operand read ports and one debug read port.
- Write-to-read bypass, a per-register pending-write scoreboard, and a sequential bulk-clear engine.
- Sits between the decode/issue stage (reads, issue marking) and the writeback stage (writes) of the MIPS core.

---
 rtl/regfile_bypass_sb_if.sv | 46 ++++
 rtl/regfile_bypass_sb.sv | 150 +++++++++++++++
 tb/tb_regfile_bypass_sb.sv | 230 +++++++++++++++++++++++
 3 files changed

// File: rtl/regfile_bypass_sb_if.sv
// Bus bundle for regfile_bypass_sb: operand reads, two writeback ports, issue marking,
// bulk clear and debug read. par_err exists only when REGFILE_PARITY_EN is defined.
interface regfile_bypass_sb_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
);
  logic [ADDR_W-1:0] rd_addr1;
  logic [ADDR_W-1:0] rd_addr2;
  logic [DATA_W-1:0] rd_data1;
  logic [DATA_W-1:0] rd_data2;
  logic              rd_busy1;
  logic              rd_busy2;
  logic              we0;
  logic [ADDR_W-1:0] waddr0;
  logic [DATA_W-1:0] wdata0;
  logic              we1;
  logic [ADDR_W-1:0] waddr1;
  logic [DATA_W-1:0] wdata1;
  logic              issue_en;
  logic [ADDR_W-1:0] issue_addr;
  logic              clr_req;
  logic              clr_busy;
  logic [ADDR_W-1:0] dbg_addr;
  logic [DATA_W-1:0] dbg_data;
`ifdef REGFILE_PARITY_EN
  logic              par_err;
`endif

  modport master (
`ifdef REGFILE_PARITY_EN
    input  par_err,
`endif
    output rd_addr1, rd_addr2, we0, waddr0, wdata0, we1, waddr1, wdata1,
    output issue_en, issue_addr, clr_req, dbg_addr,
    input  rd_data1, rd_data2, rd_busy1, rd_busy2, clr_busy, dbg_data
  );

  modport slave (
`ifdef REGFILE_PARITY_EN
    output par_err,
`endif
    input  rd_addr1, rd_addr2, we0, waddr0, wdata0, we1, waddr1, wdata1,
    input  issue_en, issue_addr, clr_req, dbg_addr,
    output rd_data1, rd_data2, rd_busy1, rd_busy2, clr_busy, dbg_data
  );
endinterface

// File: rtl/regfile_bypass_sb.sv
// Dual-write register file with write-to-read bypass, pending-write scoreboard and a
// sequential bulk-clear engine. Optional even parity per entry under REGFILE_PARITY_EN.
module regfile_bypass_sb #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int ZERO_REG = 1
) (
  input logic               clock,
  input logic               rst,
  regfile_bypass_sb_if.slave bus
);

  localparam int              DEPTH     = 2 ** ADDR_W;
  localparam bit              ZR        = (ZERO_REG != 0);
  localparam logic [ADDR_W-1:0] FIRST_IDX = ADDR_W'(ZR ? 1 : 0);
  localparam logic [ADDR_W-1:0] LAST_IDX  = {ADDR_W{1'b1}};

  typedef enum logic {S_IDLE, S_CLEAR} state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;
  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DEPTH-1:0]  pend_q, pend_d;
`ifdef REGFILE_PARITY_EN
  logic [DEPTH-1:0]  par_q;
`endif

  logic idle, clearing;
  logic we0_eff, we1_eff, issue_eff, we0_only;

  assign idle      = (state_q == S_IDLE);
  assign clearing  = (state_q == S_CLEAR);
  assign we0_eff   = bus.we0 && idle && !(ZR && bus.waddr0 == '0);
  assign we1_eff   = bus.we1 && idle && !(ZR && bus.waddr1 == '0);
  assign issue_eff = bus.issue_en && idle && !(ZR && bus.issue_addr == '0);
  // Port 0 is suppressed when port 1 targets the same entry so port 1 wins.
  assign we0_only  = we0_eff && !(we1_eff && bus.waddr1 == bus.waddr0);

  function automatic logic [DATA_W-1:0] rd_mux(
    input logic              zhit,
    input logic              hit1,
    input logic              hit0,
    input logic [DATA_W-1:0] d1,
    input logic [DATA_W-1:0] d0,
    input logic [DATA_W-1:0] arr
  );
    if (zhit)      return '0;
    else if (hit1) return d1;
    else if (hit0) return d0;
    else           return arr;
  endfunction

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (bus.clr_req) begin
          state_d = S_CLEAR;
          cnt_d   = FIRST_IDX;
        end
      end
      S_CLEAR: begin
        if (cnt_q == LAST_IDX) state_d = S_IDLE;
        else                   cnt_d   = cnt_q + 1'b1;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Scoreboard: release on writeback, then issue set overrides.
  always_comb begin
    pend_d = pend_q;
    if (clearing) begin
      pend_d[cnt_q] = 1'b0;
    end else begin
      if (we0_eff)   pend_d[bus.waddr0]     = 1'b0;
      if (we1_eff)   pend_d[bus.waddr1]     = 1'b0;
      if (issue_eff) pend_d[bus.issue_addr] = 1'b1;
    end
  end

  always_ff @(posedge clock or posedge rst) begin
    if (rst) pend_q <= '0;
    else     pend_q <= pend_d;
  end

  always_ff @(posedge clock or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (clearing) begin
      mem_q[cnt_q] <= '0;
    end else begin
      if (we0_only) mem_q[bus.waddr0] <= bus.wdata0;
      if (we1_eff)  mem_q[bus.waddr1] <= bus.wdata1;
    end
  end

`ifdef REGFILE_PARITY_EN
  always_ff @(posedge clock or posedge rst) begin
    if (rst) begin
      par_q <= '0;
    end else if (clearing) begin
      par_q[cnt_q] <= 1'b0;
    end else begin
      if (we0_only) par_q[bus.waddr0] <= ^bus.wdata0;
      if (we1_eff)  par_q[bus.waddr1] <= ^bus.wdata1;
    end
  end
`endif

  logic zhit1, zhit2, h1a1, h0a1, h1a2, h0a2;
  logic wb1, wb2;

  // Bypass is disabled during clear so reads reflect the array being wiped.
  assign zhit1 = ZR && (bus.rd_addr1 == '0);
  assign zhit2 = ZR && (bus.rd_addr2 == '0);
  assign h1a1  = idle && bus.we1 && (bus.waddr1 == bus.rd_addr1);
  assign h0a1  = idle && bus.we0 && (bus.waddr0 == bus.rd_addr1);
  assign h1a2  = idle && bus.we1 && (bus.waddr1 == bus.rd_addr2);
  assign h0a2  = idle && bus.we0 && (bus.waddr0 == bus.rd_addr2);

  assign bus.rd_data1 = rd_mux(zhit1, h1a1, h0a1, bus.wdata1, bus.wdata0, mem_q[bus.rd_addr1]);
  assign bus.rd_data2 = rd_mux(zhit2, h1a2, h0a2, bus.wdata1, bus.wdata0, mem_q[bus.rd_addr2]);
  assign bus.dbg_data = mem_q[bus.dbg_addr];

  assign wb1 = (we0_eff && bus.waddr0 == bus.rd_addr1) || (we1_eff && bus.waddr1 == bus.rd_addr1);
  assign wb2 = (we0_eff && bus.waddr0 == bus.rd_addr2) || (we1_eff && bus.waddr1 == bus.rd_addr2);
  assign bus.rd_busy1 = pend_q[bus.rd_addr1] & ~wb1;
  assign bus.rd_busy2 = pend_q[bus.rd_addr2] & ~wb2;
  assign bus.clr_busy = clearing;

`ifdef REGFILE_PARITY_EN
  logic perr1, perr2;
  assign perr1 = !(zhit1 || h1a1 || h0a1) && (^{mem_q[bus.rd_addr1], par_q[bus.rd_addr1]});
  assign perr2 = !(zhit2 || h1a2 || h0a2) && (^{mem_q[bus.rd_addr2], par_q[bus.rd_addr2]});
  assign bus.par_err = perr1 || perr2;
`endif

endmodule

// File: tb/tb_regfile_bypass_sb.sv
// Directed self-checking bench for regfile_bypass_sb (default 32x32, ZERO_REG = 1).
module tb_regfile_bypass_sb;
  localparam int DATA_W = 32;
  localparam int ADDR_W = 5;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  regfile_bypass_sb_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

  regfile_bypass_sb #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .ZERO_REG(1)) dut (
    .clock (clk),
    .rst   (rst),
    .bus   (bus)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs;
    bus.we0 = 0; bus.waddr0 = '0; bus.wdata0 = '0;
    bus.we1 = 0; bus.waddr1 = '0; bus.wdata1 = '0;
    bus.issue_en = 0; bus.issue_addr = '0; bus.clr_req = 0;
  endtask

  task automatic test_reset;
    idle_inputs();
    bus.rd_addr1 = 5'd7; bus.rd_addr2 = 5'd31; bus.dbg_addr = 5'd9;
    rst = 1'b1;
    tick(); tick();
    total++; if (bus.clr_busy !== 1'b0) begin bad++; $display("FAIL reset_clr_busy got %b want 0", bus.clr_busy); end
    total++; if (bus.dbg_data !== 32'h0) begin bad++; $display("FAIL reset_dbg got %h want 0", bus.dbg_data); end
    total++; if (bus.rd_busy1 !== 1'b0 || bus.rd_busy2 !== 1'b0) begin bad++; $display("FAIL reset_busy got %b%b want 00", bus.rd_busy1, bus.rd_busy2); end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_write_read;
    bus.we0 = 1; bus.waddr0 = 5'd9; bus.wdata0 = 32'hDEADBEEF; bus.rd_addr1 = 5'd9;
    #1;
    total++; if (bus.rd_data1 !== 32'hDEADBEEF) begin bad++; $display("FAIL bypass_r9 got %h want deadbeef", bus.rd_data1); end
    tick();
    idle_inputs();
    bus.dbg_addr = 5'd9;
    #1;
    total++; if (bus.rd_data1 !== 32'hDEADBEEF) begin bad++; $display("FAIL array_r9 got %h want deadbeef", bus.rd_data1); end
    total++; if (bus.dbg_data !== 32'hDEADBEEF) begin bad++; $display("FAIL dbg_r9 got %h want deadbeef", bus.dbg_data); end
    bus.we1 = 1; bus.waddr1 = 5'd0; bus.wdata1 = 32'h1234; bus.rd_addr2 = 5'd0;
    #1;
    total++; if (bus.rd_data2 !== 32'h0) begin bad++; $display("FAIL r0_bypass got %h want 0", bus.rd_data2); end
    tick();
    idle_inputs();
    bus.dbg_addr = 5'd0;
    #1;
    total++; if (bus.dbg_data !== 32'h0) begin bad++; $display("FAIL r0_array got %h want 0", bus.dbg_data); end
  endtask

  task automatic test_port_priority;
    bus.we0 = 1; bus.waddr0 = 5'd10; bus.wdata0 = 32'h11;
    bus.we1 = 1; bus.waddr1 = 5'd10; bus.wdata1 = 32'h22;
    bus.rd_addr2 = 5'd10;
    #1;
    total++; if (bus.rd_data2 !== 32'h22) begin bad++; $display("FAIL prio_bypass got %h want 22", bus.rd_data2); end
    tick();
    idle_inputs();
    bus.dbg_addr = 5'd10;
    #1;
    total++; if (bus.dbg_data !== 32'h22) begin bad++; $display("FAIL prio_array got %h want 22", bus.dbg_data); end
    bus.we0 = 1; bus.waddr0 = 5'd11; bus.wdata0 = 32'h33;
    bus.we1 = 1; bus.waddr1 = 5'd13; bus.wdata1 = 32'h44;
    bus.rd_addr1 = 5'd11; bus.rd_addr2 = 5'd13;
    #1;
    total++; if (bus.rd_data1 !== 32'h33) begin bad++; $display("FAIL dual_bypass0 got %h want 33", bus.rd_data1); end
    tick();
    idle_inputs();
    #1;
    total++; if (bus.rd_data1 !== 32'h33 || bus.rd_data2 !== 32'h44) begin bad++; $display("FAIL dual_array got %h %h want 33 44", bus.rd_data1, bus.rd_data2); end
  endtask

  task automatic test_scoreboard;
    bus.issue_en = 1; bus.issue_addr = 5'd12;
    tick();
    idle_inputs();
    bus.rd_addr1 = 5'd12;
    #1;
    total++; if (bus.rd_busy1 !== 1'b1) begin bad++; $display("FAIL sb_issue got %b want 1", bus.rd_busy1); end
    bus.we0 = 1; bus.waddr0 = 5'd12; bus.wdata0 = 32'h5;
    #1;
    total++; if (bus.rd_busy1 !== 1'b0 || bus.rd_data1 !== 32'h5) begin bad++; $display("FAIL sb_release got %b %h want 0 5", bus.rd_busy1, bus.rd_data1); end
    tick();
    idle_inputs();
    #1;
    total++; if (bus.rd_busy1 !== 1'b0) begin bad++; $display("FAIL sb_cleared got %b want 0", bus.rd_busy1); end
    bus.issue_en = 1; bus.issue_addr = 5'd12;
    bus.we1 = 1; bus.waddr1 = 5'd12; bus.wdata1 = 32'h6;
    tick();
    idle_inputs();
    #1;
    total++; if (bus.rd_busy1 !== 1'b1) begin bad++; $display("FAIL sb_set_wins got %b want 1", bus.rd_busy1); end
    bus.issue_en = 1; bus.issue_addr = 5'd0;
    tick();
    idle_inputs();
    bus.rd_addr2 = 5'd0;
    #1;
    total++; if (bus.rd_busy2 !== 1'b0) begin bad++; $display("FAIL sb_r0 got %b want 0", bus.rd_busy2); end
  endtask

  task automatic test_bulk_clear;
    int n;
    for (int i = 1; i < 32; i++) begin
      bus.we0 = 1; bus.waddr0 = 5'(i); bus.wdata0 = 32'h0101_0100 * i + 32'h7;
      tick();
    end
    idle_inputs();
    bus.issue_en = 1; bus.issue_addr = 5'd5;  tick();
    bus.issue_addr = 5'd20; tick();
    bus.issue_addr = 5'd31; tick();
    idle_inputs();
    bus.rd_addr1 = 5'd20;
    #1;
    total++; if (bus.rd_busy1 !== 1'b1) begin bad++; $display("FAIL clr_pre_busy got %b want 1", bus.rd_busy1); end
    bus.clr_req = 1;
    tick();
    bus.clr_req = 0;
    n = 0;
    while (bus.clr_busy === 1'b1 && n < 100) begin
      n++;
      idle_inputs();
      if (n == 10) begin
        bus.we1 = 1; bus.waddr1 = 5'd5; bus.wdata1 = 32'hFFFF;
        bus.issue_en = 1; bus.issue_addr = 5'd6; bus.clr_req = 1;
        bus.rd_addr1 = 5'd5;
        #1;
        total++; if (bus.rd_data1 !== 32'h0) begin bad++; $display("FAIL clr_no_bypass got %h want 0", bus.rd_data1); end
      end
      tick();
    end
    idle_inputs();
    total++; if (n != 31) begin bad++; $display("FAIL clr_duration got %0d want 31", n); end
    for (int i = 0; i < 32; i++) begin
      bus.dbg_addr = 5'(i); bus.rd_addr1 = 5'(i); bus.rd_addr2 = 5'(i);
      #1;
      total++;
      if (bus.dbg_data !== 32'h0 || bus.rd_busy1 !== 1'b0 || bus.rd_busy2 !== 1'b0) begin
        bad++; $display("FAIL clr_entry%0d got %h busy %b want 0 busy 0", i, bus.dbg_data, bus.rd_busy1);
      end
    end
    total++; if (bus.clr_busy !== 1'b0) begin bad++; $display("FAIL clr_restart got %b want 0", bus.clr_busy); end
  endtask

  task automatic test_clear_abort;
    bus.we0 = 1; bus.waddr0 = 5'd3;  bus.wdata0 = 32'hAA;
    bus.we1 = 1; bus.waddr1 = 5'd17; bus.wdata1 = 32'hBB;
    tick();
    bus.waddr0 = 5'd31; bus.wdata0 = 32'hCC; bus.we1 = 0;
    tick();
    idle_inputs();
    bus.clr_req = 1;
    tick();
    bus.clr_req = 0;
    for (int i = 1; i < 10; i++) tick();
    total++; if (bus.clr_busy !== 1'b1) begin bad++; $display("FAIL abort_pre got %b want 1", bus.clr_busy); end
    rst = 1'b1;
    #1;
    total++; if (bus.clr_busy !== 1'b0) begin bad++; $display("FAIL abort_busy got %b want 0", bus.clr_busy); end
    for (int i = 0; i < 32; i++) begin
      bus.dbg_addr = 5'(i);
      #1;
      total++; if (bus.dbg_data !== 32'h0) begin bad++; $display("FAIL abort_entry%0d got %h want 0", i, bus.dbg_data); end
    end
    tick();
    rst = 1'b0;
    bus.we0 = 1; bus.waddr0 = 5'd4; bus.wdata0 = 32'h77;
    tick();
    idle_inputs();
    bus.dbg_addr = 5'd4;
    #1;
    total++; if (bus.dbg_data !== 32'h77) begin bad++; $display("FAIL abort_idle_write got %h want 77", bus.dbg_data); end
  endtask

`ifdef REGFILE_PARITY_EN
  task automatic test_parity;
    bus.we0 = 1; bus.waddr0 = 5'd3; bus.wdata0 = 32'h0F;
    tick();
    idle_inputs();
    bus.rd_addr1 = 5'd3; bus.rd_addr2 = 5'd4;
    #1;
    total++; if (bus.par_err !== 1'b0) begin bad++; $display("FAIL par_clean got %b want 0", bus.par_err); end
    force dut.mem_q[3] = 32'h0E;
    #1;
    total++; if (bus.par_err !== 1'b1) begin bad++; $display("FAIL par_flip got %b want 1", bus.par_err); end
    bus.we0 = 1; bus.waddr0 = 5'd3; bus.wdata0 = 32'h1;
    #1;
    total++; if (bus.par_err !== 1'b0) begin bad++; $display("FAIL par_bypassed got %b want 0", bus.par_err); end
    release dut.mem_q[3];
    tick();
    idle_inputs();
    #1;
    total++; if (bus.par_err !== 1'b0) begin bad++; $display("FAIL par_rewrite got %b want 0", bus.par_err); end
  endtask
`endif

  initial begin
    idle_inputs();
    bus.rd_addr1 = '0; bus.rd_addr2 = '0; bus.dbg_addr = '0;
    test_reset();
    test_write_read();
    test_port_priority();
    test_scoreboard();
    test_bulk_clear();
    test_clear_abort();
`ifdef REGFILE_PARITY_EN
    test_parity();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout reached without completion");
    $fatal(1, "timeout");
  end
endmodule
